// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: issues one request per load/store to a
// variable-latency data memory and freezes the pipeline until it answers.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Sig_Memory_Read_Enable,
    input  logic                  i_Sig_Memory_Write_Enable,
    input  logic [ADDR_WIDTH-1:0] i_ALU_Result,
    input  logic [DATA_WIDTH-1:0] i_Write_Data,
    output logic                  o_Mem_Req,
    output logic                  o_Mem_Write,
    output logic [ADDR_WIDTH-1:0] o_Mem_Address,
    output logic [DATA_WIDTH-1:0] o_Mem_Write_Data,
    input  logic                  i_Mem_Ready,
    input  logic [DATA_WIDTH-1:0] i_Mem_Read_Data,
    output logic [DATA_WIDTH-1:0] o_Memory_Read_Value,
    output logic                  o_Sig_Freeze,
    output logic                  o_Sig_Timeout_Error
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_en;
    logic             wait_expired;

    assign mem_en       = i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable;
    // Ready arriving on the last allowed cycle takes precedence over the timeout.
    assign wait_expired = (state == ACCESS) && !i_Mem_Ready
                          && (wait_cnt == CNT_W'(MAX_WAIT - 1));

    assign o_Mem_Req    = (state == ACCESS);
    assign o_Sig_Freeze = ((state == IDLE) && mem_en) || (state == ACCESS);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (mem_en) next_state = ACCESS;
            ACCESS:  if (i_Mem_Ready || wait_expired) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // DONE is a deliberate one-cycle release so the held instruction is not
    // reissued while the pipeline advances past it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt            <= '0;
            o_Mem_Write         <= 1'b0;
            o_Mem_Address       <= '0;
            o_Mem_Write_Data    <= '0;
            o_Memory_Read_Value <= '0;
            o_Sig_Timeout_Error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        wait_cnt         <= '0;
                        o_Mem_Write      <= i_Sig_Memory_Write_Enable;
                        o_Mem_Address    <= i_ALU_Result;
                        o_Mem_Write_Data <= i_Write_Data;
                    end
                end
                ACCESS: begin
                    if (i_Mem_Ready) begin
                        if (!o_Mem_Write) o_Memory_Read_Value <= i_Mem_Read_Data;
                    end else if (wait_expired) begin
                        o_Sig_Timeout_Error <= 1'b1;
                        if (!o_Mem_Write) o_Memory_Read_Value <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected transactions are queued when
// stimulus is driven and compared when the controller reaches DONE.
module tb_mem_access_ctrl;

    localparam int DW       = 32;
    localparam int AW       = 32;
    localparam int MAX_WAIT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_en, wr_en;
    logic [AW-1:0] alu_result;
    logic [DW-1:0] write_data;
    logic          mem_req, mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_ready;
    logic [DW-1:0] mem_read_data;
    logic [DW-1:0] read_value;
    logic          freeze, timeout_error;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          is_store;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rvalue;
        int            req_cycles;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_value = '0;
    logic          model_err   = 1'b0;

    mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .i_Sig_Memory_Read_Enable  (rd_en),
        .i_Sig_Memory_Write_Enable (wr_en),
        .i_ALU_Result              (alu_result),
        .i_Write_Data              (write_data),
        .o_Mem_Req                 (mem_req),
        .o_Mem_Write               (mem_write),
        .o_Mem_Address             (mem_address),
        .o_Mem_Write_Data          (mem_write_data),
        .i_Mem_Ready               (mem_ready),
        .i_Mem_Read_Data           (mem_read_data),
        .o_Memory_Read_Value       (read_value),
        .o_Sig_Freeze              (freeze),
        .o_Sig_Timeout_Error       (timeout_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Entered and left at posedge+1. waits < 0 means the memory never answers.
    task automatic mem_op(input logic rd, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                          input int waits, input logic drop_enables);
        exp_t          e, got;
        logic          timeout;
        int            req_cycles, freeze_cycles;
        logic          obs_write;
        logic [AW-1:0] obs_addr;
        logic [DW-1:0] obs_wdata;
        bit            done_seen;

        timeout    = (waits < 0) || (waits >= MAX_WAIT);
        e.is_store = wr;
        e.addr     = addr;
        e.wdata    = wdata;
        if (!wr) model_value = timeout ? '0 : rdata;
        if (timeout) model_err = 1'b1;
        e.rvalue     = model_value;
        e.req_cycles = timeout ? MAX_WAIT : waits + 1;
        e.err        = model_err;
        sb.push_back(e);

        rd_en = rd; wr_en = wr; alu_result = addr; write_data = wdata;
        mem_ready = 1'b0; mem_read_data = rdata;
        @(negedge clk);
        freeze_cycles = int'(freeze);
        check("idle_req_low", 32'(mem_req), 32'd0);

        req_cycles = 0;
        done_seen  = 1'b0;
        obs_write  = 1'bx; obs_addr = 'x; obs_wdata = 'x;
        for (int i = 0; i < 3 * MAX_WAIT; i++) begin
            @(posedge clk); #1;
            mem_ready = (waits >= 0) && (req_cycles == waits);
            @(negedge clk);
            if (!mem_req) begin
                done_seen = 1'b1;
                break;
            end
            if (req_cycles == 0) begin
                obs_write = mem_write; obs_addr = mem_address; obs_wdata = mem_write_data;
            end
            req_cycles++;
            freeze_cycles += int'(freeze);
        end
        if (!done_seen) check("done_within_bound", 32'd0, 32'd1);

        got = sb.pop_front();
        check("done_freeze_low", 32'(freeze), 32'd0);
        check("req_cycles", 32'(req_cycles), 32'(got.req_cycles));
        check("freeze_cycles", 32'(freeze_cycles), 32'(got.req_cycles + 1));
        check("mem_write", 32'(obs_write), 32'(got.is_store));
        check("mem_address", obs_addr, got.addr);
        if (got.is_store) check("mem_write_data", obs_wdata, got.wdata);
        check("read_value", read_value, got.rvalue);
        check("timeout_error", 32'(timeout_error), 32'(got.err));

        @(posedge clk); #1;
        mem_ready = 1'b0;
        if (drop_enables) begin
            rd_en = 1'b0; wr_en = 1'b0;
            @(negedge clk);
            check("post_done_req", 32'(mem_req), 32'd0);
            check("post_done_freeze", 32'(freeze), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        alu_result = '0; write_data = '0; mem_ready = 1'b0; mem_read_data = '0;
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_write", 32'(mem_write), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_read_value", read_value, 32'd0);
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_error", 32'(timeout_error), 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Non-memory instruction: no freeze, no request.
        @(negedge clk);
        check("nonmem_freeze", 32'(freeze), 32'd0);
        @(posedge clk); #1;

        mem_op(1, 0, 32'h0000_0100, 32'h0, 32'hABCD_1234, 0, 1);
        mem_op(0, 1, 32'h0000_0200, 32'h9876_5432, 32'h1357_9BDF, 3, 1);
        mem_op(1, 1, 32'h0000_0010, 32'h5566_7788, 32'hDEAD_BEEF, 0, 1);
        mem_op(1, 0, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, -1, 1);
        mem_op(1, 0, 32'h0000_0304, 32'h0, 32'h2468_ACE0, 2, 1);
        mem_op(0, 1, 32'h0000_0308, 32'hCAFE_0001, 32'h0, MAX_WAIT - 1, 1);

        mem_op(1, 0, 32'h0000_0400, 32'h0, 32'h1122_3344, 0, 0);
        mem_op(1, 0, 32'h0000_0404, 32'h0, 32'h5566_7788, 0, 1);

        for (int i = 0; i < 4; i++) begin
            logic wr;
            wr = 1'($urandom_range(1));
            mem_op(!wr, wr, $urandom, $urandom, $urandom, int'($urandom_range(5)), 1);
        end

        // Reset in the middle of an outstanding load.
        rd_en = 1'b1; alu_result = 32'h0000_0500; mem_read_data = 32'h7777_7777;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1; rd_en = 1'b0;
        #1;
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_freeze", 32'(freeze), 32'd0);
        check("midrst_write", 32'(mem_write), 32'd0);
        check("midrst_addr", mem_address, 32'd0);
        check("midrst_wdata", mem_write_data, 32'd0);
        check("midrst_read_value", read_value, 32'd0);
        check("midrst_error", 32'(timeout_error), 32'd0);
        rd_en = 1'b1;
        #1;
        check("rst_freeze_follows_en", 32'(freeze), 32'd1);
        rd_en = 1'b0;
        model_value = '0;
        model_err   = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        mem_op(1, 0, 32'h0000_0600, 32'h0, 32'hFFEE_DDCC, 1, 1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
